// File: rtl/wall_scroller.sv
// rtl/wall_scroller.sv - scrolling wall geometry, respawn, freeze-on-hit and score
//
// Purpose:
//   Moves a single wall (pipe pair) left by STEP pixels per frame tick and
//   respawns it at the right edge with a pseudo-random gap height. Motion
//   freezes while the collision checker reports a hit. Walls that clear the
//   bird are counted into a saturating 8-bit score.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   start         in   one-cycle pulse, begins or restarts a game
//   tick          in   frame pulse, one step per high cycle
//   touched       in   collision flag from the collision checker
//   wall_xleft    out  left edge of the wall
//   wall_xright   out  right edge of the wall
//   wall_topy     out  top of the gap (bottom of the upper pipe)
//   wall_bottomy  out  bottom of the gap (top of the lower pipe)
//   wall_valid    out  geometry is meaningful (RUN or HIT)
//   passed        out  one-cycle pulse when the wall clears the bird
//   score         out  walls passed this game, saturating at 255
//   state_hit     out  high while frozen after a collision

module wall_scroller #(
  parameter int XW       = 9,
  parameter int YW       = 7,
  parameter int SCREEN_W = 160,
  parameter int WALL_W   = 16,
  parameter int GAP_H    = 40,
  parameter int Y_MIN    = 8,
  parameter int GAP_MASK = 63,
  parameter int STEP     = 2,
  parameter int BIRD_X   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          tick,
  input  logic          touched,
  output logic [XW-1:0] wall_xleft,
  output logic [XW-1:0] wall_xright,
  output logic [YW-1:0] wall_topy,
  output logic [YW-1:0] wall_bottomy,
  output logic          wall_valid,
  output logic          passed,
  output logic [7:0]    score,
  output logic          state_hit
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HIT  = 2'd2;

  localparam logic [XW-1:0] SPAWN_XL = XW'(SCREEN_W);
  localparam logic [XW-1:0] SPAWN_XR = XW'(SCREEN_W + WALL_W - 1);
  localparam logic [XW-1:0] STEP_V   = XW'(STEP);
  localparam logic [XW-1:0] BIRD_XV  = XW'(BIRD_X);
  localparam logic [YW-1:0] Y_MIN_V  = YW'(Y_MIN);
  localparam logic [YW-1:0] GAP_H_V  = YW'(GAP_H);
  localparam logic [7:0]    MASK_V   = 8'(GAP_MASK);
  localparam logic [7:0]    SEED     = 8'hA5;

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] xleft_q, xleft_d;
  logic [XW-1:0] xright_q, xright_d;
  logic [YW-1:0] topy_q, topy_d;
  logic [YW-1:0] bottomy_q, bottomy_d;
  logic          valid_q, valid_d;
  logic          passed_q, passed_d;
  logic [7:0]    score_q, score_d;
  logic          hit_q, hit_d;
  logic [7:0]    lfsr_q, lfsr_d;

  logic          lfsr_fb;
  logic [YW-1:0] spawn_topy;
  logic [XW-1:0] moved_xright;
  logic [XW-1:0] moved_xleft;
  logic          crosses_bird;
  logic [7:0]    score_inc;
  logic          do_spawn;

  // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1; a maximal-length polynomial, so the
  // register never reaches zero from a nonzero seed.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Gap height is taken from the LFSR value present in the spawn cycle.
  assign spawn_topy   = Y_MIN_V + YW'(lfsr_q & MASK_V);

  assign moved_xright = xright_q - STEP_V;
  assign moved_xleft  = (xleft_q < STEP_V) ? '0 : (xleft_q - STEP_V);
  assign crosses_bird = (xright_q >= BIRD_XV) && (moved_xright < BIRD_XV);
  assign score_inc    = (score_q == 8'hFF) ? score_q : (score_q + 8'd1);

  always_comb begin
    state_d   = state_q;
    xleft_d   = xleft_q;
    xright_d  = xright_q;
    topy_d    = topy_q;
    bottomy_d = bottomy_q;
    passed_d  = 1'b0;
    score_d   = score_q;
    do_spawn  = 1'b0;
    lfsr_d    = {lfsr_q[6:0], lfsr_fb};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          do_spawn = 1'b1;
          score_d  = 8'd0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (start) begin
          do_spawn = 1'b1;
          score_d  = 8'd0;
        end else if (touched) begin
          // Collision wins over a coincident tick: freeze where we are.
          state_d = S_HIT;
        end else if (tick) begin
          if (xright_q < STEP_V) begin
            // Respawn instead of wrapping; never counts as a pass.
            do_spawn = 1'b1;
          end else begin
            xright_d = moved_xright;
            xleft_d  = moved_xleft;
            if (crosses_bird) begin
              passed_d = 1'b1;
              score_d  = score_inc;
            end
          end
        end
      end
      S_HIT: begin
        if (start) begin
          do_spawn = 1'b1;
          score_d  = 8'd0;
          state_d  = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_spawn) begin
      xleft_d   = SPAWN_XL;
      xright_d  = SPAWN_XR;
      topy_d    = spawn_topy;
      bottomy_d = spawn_topy + GAP_H_V;
    end

    // Status flags are registered from the next state so they line up with
    // the geometry they describe.
    valid_d = (state_d == S_RUN) || (state_d == S_HIT);
    hit_d   = (state_d == S_HIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      xleft_q   <= '0;
      xright_q  <= '0;
      topy_q    <= '0;
      bottomy_q <= '0;
      valid_q   <= 1'b0;
      passed_q  <= 1'b0;
      score_q   <= 8'd0;
      hit_q     <= 1'b0;
      lfsr_q    <= SEED;
    end else begin
      state_q   <= state_d;
      xleft_q   <= xleft_d;
      xright_q  <= xright_d;
      topy_q    <= topy_d;
      bottomy_q <= bottomy_d;
      valid_q   <= valid_d;
      passed_q  <= passed_d;
      score_q   <= score_d;
      hit_q     <= hit_d;
      lfsr_q    <= lfsr_d;
    end
  end

  assign wall_xleft   = xleft_q;
  assign wall_xright  = xright_q;
  assign wall_topy    = topy_q;
  assign wall_bottomy = bottomy_q;
  assign wall_valid   = valid_q;
  assign passed       = passed_q;
  assign score        = score_q;
  assign state_hit    = hit_q;

endmodule
